banner_scroller: RTL and testbench

Parametrised successor to the fixed banner-word ROMs. It holds a banner bitmap as a parameter, replicates each source row vertically by SCALE, and serves a WIN_W-wide horizontal window of the banner to the display scanner on request. The window can be static, scroll left, scroll right or blink, paced by an internal tick divider. It sits between the display row scanner and the LED-matrix/VGA pixel path.

---
 rtl/banner_scroller.sv | 136 +++++++++++++
 tb/tb_banner_scroller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/banner_scroller.sv
// Parametrised banner bitmap served as a WIN_W-wide scrolling/blinking window, rows replicated by SCALE.
// Latency 2 from row_req to row_valid, one request per cycle; no backpressure, the scanner must accept every response.
module banner_scroller #(
  parameter int WORD_W   = 71,
  parameter int SRC_ROWS = 5,
  parameter int SCALE    = 3,
  parameter int WIN_W    = 32,
  parameter int TICK_DIV = 1000000,
  parameter logic [SRC_ROWS*WORD_W-1:0] BITMAP = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic [1:0]                            mode,
  input  logic                                  row_req,
  input  logic [$clog2(SRC_ROWS*SCALE)-1:0]     row_idx,
  output logic                                  row_valid,
  output logic [WIN_W-1:0]                      row_data,
  output logic [$clog2(WORD_W)-1:0]             offset,
  output logic                                  step
);

  localparam int N_ROWS = SRC_ROWS * SCALE;
  localparam int IDX_W  = $clog2(N_ROWS);
  localparam int OFF_W  = $clog2(WORD_W);
  localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SRC_W  = (SRC_ROWS > 1) ? $clog2(SRC_ROWS) : 1;
  localparam int SUM_W  = $clog2(2 * WORD_W);

  logic [DIV_W-1:0]  div_cnt;
  logic              step_q;
  logic              visible;
  logic              div_last;

  logic              s1_vld;
  logic [SRC_W-1:0]  s1_src;
  logic              s1_oor;
  logic [OFF_W-1:0]  s1_off;
  logic              s1_vis;

  logic [SRC_W-1:0]  src_dec;
  logic              oor_dec;
  logic [WORD_W-1:0] sel_row;
  logic [WIN_W-1:0]  win;
  logic [SUM_W-1:0]  col;
  logic [OFF_W-1:0]  bit_idx;

  assign div_last = (div_cnt == DIV_W'(TICK_DIV - 1));
  // A pending step is dropped if en falls in the same cycle, so step never pulses while disabled.
  assign step = step_q & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= en & div_last;
      if (en) div_cnt <= div_last ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset  <= '0;
      visible <= 1'b1;
    end else begin
      if (mode != 2'b11)  visible <= 1'b1;
      else if (step)      visible <= ~visible;
      if (step && mode == 2'b01)
        offset <= (offset == OFF_W'(WORD_W - 1)) ? '0 : offset + 1'b1;
      else if (step && mode == 2'b10)
        offset <= (offset == '0) ? OFF_W'(WORD_W - 1) : offset - 1'b1;
    end
  end

  // Constant divide by SCALE unrolled into a lookup over every legal row index.
  always_comb begin
    src_dec = '0;
    oor_dec = 1'b1;
    for (int i = 0; i < N_ROWS; i++) begin
      if (row_idx == IDX_W'(i)) begin
        src_dec = SRC_W'(i / SCALE);
        oor_dec = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_src <= '0;
      s1_oor <= 1'b0;
      s1_off <= '0;
      s1_vis <= 1'b0;
    end else begin
      s1_vld <= row_req;
      if (row_req) begin
        s1_src <= src_dec;
        s1_oor <= oor_dec;
        s1_off <= offset;
        s1_vis <= visible;
      end
    end
  end

  always_comb begin
    sel_row = '0;
    for (int r = 0; r < SRC_ROWS; r++) begin
      if (s1_src == SRC_W'(r)) sel_row = BITMAP[r*WORD_W +: WORD_W];
    end
  end

  // off+k stays below 2*WORD_W, so one conditional subtract wraps the window.
  always_comb begin
    win     = '0;
    col     = '0;
    bit_idx = '0;
    for (int k = 0; k < WIN_W; k++) begin
      col = SUM_W'(s1_off) + SUM_W'(k);
      if (col >= SUM_W'(WORD_W)) col = col - SUM_W'(WORD_W);
      bit_idx = OFF_W'(WORD_W - 1) - col[OFF_W-1:0];
      win[WIN_W-1-k] = sel_row[bit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_valid <= 1'b0;
      row_data  <= '0;
    end else begin
      row_valid <= s1_vld;
      if (s1_vld) row_data <= (s1_oor || !s1_vis) ? '0 : win;
    end
  end

endmodule

// File: tb/tb_banner_scroller.sv
// Bench for banner_scroller: directed reset/static/scroll/blink steps plus randomized traffic,
// compared cycle by cycle against an arithmetic reference model of offset, blink and window contents.
module tb_banner_scroller;

  localparam int W  = 71;
  localparam int TD = 2;
  localparam logic [W-1:0] ROW0 = {1'b1, 70'b0};
  localparam logic [W-1:0] ROW1 = 71'h2A_AAAA_AAAA_AAAA_AAAB;
  localparam logic [W-1:0] ROW2 = 71'h3F_0000_FFFF_0000_FF01;
  localparam logic [W-1:0] ROW3 = 71'h12_3456_789A_BCDE_F013;
  localparam logic [W-1:0] ROW4 = 71'h00_0000_0000_0000_0001;
  localparam logic [5*W-1:0] BM = {ROW4, ROW3, ROW2, ROW1, ROW0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic        row_req;
  logic [3:0]  row_idx;
  logic        row_valid;
  logic [31:0] row_data;
  logic [6:0]  offset;
  logic        step;

  banner_scroller #(.TICK_DIV(TD), .BITMAP(BM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .row_req(row_req), .row_idx(row_idx),
    .row_valid(row_valid), .row_data(row_data), .offset(offset), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t q[$];

  logic [5*W-1:0] bmv;
  logic [W-1:0]   row1v;
  int   checks = 0, errors = 0, cyc = 0;
  int   m_cnt, m_off;
  bit   m_vis, m_stepq;
  logic [31:0] m_last;

  function automatic logic [31:0] window(int src, int off);
    logic [31:0] w;
    int col;
    for (int k = 0; k < 32; k++) begin
      col = (off + k) % W;
      w[31-k] = bmv[src*W + (W - 1 - col)];
    end
    return w;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_off = 0; m_vis = 1'b1; m_stepq = 1'b0; m_last = '0;
  endtask

  // Advance the model by one clock from the inputs currently applied, then compare after the edge.
  task automatic cycle();
    bit stepc;
    logic [31:0] d;
    bit exp_vld;
    stepc = m_stepq && en;
    if (row_req) begin
      d = (row_idx >= 15 || !m_vis) ? 32'h0 : window(int'(row_idx) / 3, m_off);
      q.push_back('{due: cyc + 2, data: d});
    end
    if (en) begin
      m_stepq = (m_cnt == TD - 1);
      m_cnt   = (m_cnt + 1) % TD;
    end else begin
      m_stepq = 1'b0;
    end
    if (stepc) begin
      case (mode)
        2'b01: m_off = (m_off + 1) % W;
        2'b10: m_off = (m_off + W - 1) % W;
        2'b11: m_vis = !m_vis;
        default: ;
      endcase
    end
    if (mode != 2'b11) m_vis = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    exp_vld = (q.size() > 0) && (q[0].due == cyc);
    if (exp_vld) m_last = q.pop_front().data;
    check("row_valid", 64'(row_valid), 64'(exp_vld));
    check("row_data", 64'(row_data), 64'(m_last));
    check("offset", 64'(offset), 64'(m_off));
    check("step", 64'(step), 64'(m_stepq && en));
  endtask

  initial begin
    int n;
    logic [31:0] stat_exp [5];
    int stat_idx [5];
    bmv = BM;
    row1v = ROW1;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; row_req = 1'b0; row_idx = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_row_data", 64'(row_data), 64'd0);
    check("rst_offset", 64'(offset), 64'd0);
    check("rst_step", 64'(step), 64'd0);
    rst_n = 1'b1;

    // Reset asserted with a request in flight: it must vanish
    row_req = 1'b1; row_idx = 4'd0;
    cycle();
    row_req = 1'b0; rst_n = 1'b0;
    #1;
    check("midreq_row_valid", 64'(row_valid), 64'd0);
    check("midreq_row_data", 64'(row_data), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) cycle();

    // Static fetch, back-to-back requests, out-of-range index
    stat_idx = '{0, 1, 2, 3, 15};
    stat_exp = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, row1v[70:39], 32'h0};
    for (int i = 0; i < 7; i++) begin
      row_req = (i < 5);
      row_idx = (i < 5) ? 4'(stat_idx[i]) : 4'd0;
      cycle();
      if (i >= 1 && i <= 5) begin
        check("static_valid", 64'(row_valid), 64'd1);
        check("static_data", 64'(row_data), 64'(stat_exp[i-1]));
      end
    end
    row_req = 1'b0;
    cycle();

    // Scroll left until offset 70, then freeze and fetch row 0
    en = 1'b1; mode = 2'b01; n = 0;
    while (m_off != 70 && n < 400) begin
      row_req = 1'($urandom_range(0, 1)); row_idx = 4'($urandom_range(0, 15));
      cycle(); n++;
    end
    checks++;
    assert (n < 400) else begin errors++; $error("FAIL scroll_left_timeout observed=%0d expected=<400", n); end
    en = 1'b0; row_req = 1'b1; row_idx = 4'd1;
    cycle();
    row_req = 1'b0;
    repeat (2) cycle();
    check("wrap70_data", 64'(row_data), 64'h4000_0000);

    // Continue to wrap back to 0
    en = 1'b1; n = 0;
    while (m_off != 0 && n < 20) begin
      row_req = 1'b1; row_idx = 4'($urandom_range(0, 14));
      cycle(); n++;
    end
    check("wrap_to_0", 64'(offset), 64'd0);

    // Scroll right from 0 wraps to 70
    mode = 2'b10; row_req = 1'b0; n = 0;
    while (m_off == 0 && n < 20) begin cycle(); n++; end
    check("right_wrap", 64'(offset), 64'd70);
    en = 1'b0;
    repeat (10) cycle();
    check("frozen_offset", 64'(offset), 64'd70);

    // Blink, then leave blink mode
    en = 1'b1; mode = 2'b11; row_req = 1'b1; row_idx = 4'd6;
    repeat (12) cycle();
    mode = 2'b00;
    repeat (4) cycle();
    check("unblink_data", 64'(row_data), 64'(window(2, 70)));
    row_req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      row_req = 1'($urandom_range(0, 1));
      row_idx = 4'($urandom_range(0, 15));
      cycle();
    end
    row_req = 1'b0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
